// File: rtl/mem_arbiter_if.sv
`timescale 1ns/1ps
// mem_arbiter_if
// Bundles the two cache miss ports and the line-sized memory port that meet
// at mem_arbiter.
//   master : the arbiter's view. It takes the icache/dcache requests and the
//            memory response, and drives the cache responses and the memory
//            strobes, address and write data.
//   slave  : the environment's view (caches plus main memory).
// Signals:
//   i_read/i_addr            icache line read request and address
//   i_rdata/i_resp           line data and completion pulse to icache
//   d_read/d_write/d_addr/d_wdata  dcache line read/writeback request
//   d_rdata/d_resp           line data and completion pulse to dcache
//   m_read/m_write/m_addr/m_wdata  memory strobes, address, write data
//   m_rdata/m_resp           memory read data and completion pulse
interface mem_arbiter_if #(
  parameter int LINE_W = 256,
  parameter int ADDR_W = 32
);
  logic              i_read;
  logic [ADDR_W-1:0] i_addr;
  logic [LINE_W-1:0] i_rdata;
  logic              i_resp;

  logic              d_read;
  logic              d_write;
  logic [ADDR_W-1:0] d_addr;
  logic [LINE_W-1:0] d_wdata;
  logic [LINE_W-1:0] d_rdata;
  logic              d_resp;

  logic              m_read;
  logic              m_write;
  logic [ADDR_W-1:0] m_addr;
  logic [LINE_W-1:0] m_wdata;
  logic [LINE_W-1:0] m_rdata;
  logic              m_resp;

  modport master (
    input  i_read, i_addr,
    input  d_read, d_write, d_addr, d_wdata,
    input  m_rdata, m_resp,
    output i_rdata, i_resp,
    output d_rdata, d_resp,
    output m_read, m_write, m_addr, m_wdata
  );

  modport slave (
    output i_read, i_addr,
    output d_read, d_write, d_addr, d_wdata,
    output m_rdata, m_resp,
    input  i_rdata, i_resp,
    input  d_rdata, d_resp,
    input  m_read, m_write, m_addr, m_wdata
  );
endinterface

// File: rtl/mem_arbiter.sv
`timescale 1ns/1ps
// mem_arbiter
// Shares one line-sized memory port between the instruction cache
// (read-only) and the data cache (read/write). One line transaction is in
// flight at a time. Data requests win over instruction requests, but once
// STARVE_MAX data grants have gone by while an instruction fetch waited, the
// instruction side is forced through.
// Ports:
//   clk    rising-edge system clock
//   rst_n  asynchronous active-low reset
//   bus    mem_arbiter_if.master: cache miss ports and memory port
// Timing:
//   request seen in IDLE at cycle N -> strobe from cycle N+1
//   resp pulses combinationally in the m_resp cycle; strobes drop next cycle
//   at least one IDLE cycle separates transactions
module mem_arbiter #(
  parameter int LINE_W     = 256,
  parameter int ADDR_W     = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  mem_arbiter_if.master bus
);

  localparam int SW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    I_BUSY = 2'd1,
    D_BUSY = 2'd2
  } state_t;

  state_t            state, state_nxt;
  logic [SW-1:0]     starve, starve_nxt;
  logic              op_write, op_write_nxt;
  logic [ADDR_W-1:0] addr_q, addr_nxt;
  logic [LINE_W-1:0] wdata_q, wdata_nxt;

  logic              d_req;
  logic              grant_i;
  logic              grant_d;

  // ---------------------------------------------------------------------
  // State and latched transaction registers
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      starve   <= '0;
      op_write <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
    end else begin
      state    <= state_nxt;
      starve   <= starve_nxt;
      op_write <= op_write_nxt;
      addr_q   <= addr_nxt;
      wdata_q  <= wdata_nxt;
    end
  end

  // ---------------------------------------------------------------------
  // Arbitration and next state
  // ---------------------------------------------------------------------
  always_comb begin
    d_req        = bus.d_read | bus.d_write;
    grant_i      = 1'b0;
    grant_d      = 1'b0;
    state_nxt    = state;
    starve_nxt   = starve;
    op_write_nxt = op_write;
    addr_nxt     = addr_q;
    wdata_nxt    = wdata_q;

    unique case (state)
      IDLE: begin
        // The instruction side only wins when the data side is quiet or
        // has used up its allowance of consecutive grants.
        if (bus.i_read && (!d_req || starve == STARVE_LIM)) begin
          grant_i = 1'b1;
        end else if (d_req) begin
          grant_d = 1'b1;
        end
      end
      I_BUSY: begin
        if (bus.m_resp) state_nxt = IDLE;
      end
      D_BUSY: begin
        if (bus.m_resp) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase

    if (grant_i) begin
      state_nxt    = I_BUSY;
      addr_nxt     = bus.i_addr;
      op_write_nxt = 1'b0;
      starve_nxt   = '0;
    end

    if (grant_d) begin
      state_nxt    = D_BUSY;
      addr_nxt     = bus.d_addr;
      wdata_nxt    = bus.d_wdata;
      // Read and write together is illegal; the write wins so a dirty line
      // is never lost.
      op_write_nxt = bus.d_write;
      if (!bus.i_read) begin
        starve_nxt = '0;
      end else if (starve != STARVE_LIM) begin
        starve_nxt = starve + SW'(1);
      end
    end
  end

  // ---------------------------------------------------------------------
  // Outputs: strobes follow the registered state, responses are gated
  // copies of m_resp, read data is passed straight through.
  // ---------------------------------------------------------------------
  assign bus.m_read  = (state == I_BUSY) || ((state == D_BUSY) && !op_write);
  assign bus.m_write = (state == D_BUSY) && op_write;
  assign bus.m_addr  = addr_q;
  assign bus.m_wdata = wdata_q;

  assign bus.i_resp  = (state == I_BUSY) && bus.m_resp;
  assign bus.d_resp  = (state == D_BUSY) && bus.m_resp;
  assign bus.i_rdata = bus.m_rdata;
  assign bus.d_rdata = bus.m_rdata;

  // ---------------------------------------------------------------------
  // Output guarantees
  // ---------------------------------------------------------------------
  a_one_strobe: assert property (@(posedge clk) disable iff (!rst_n)
    !(bus.m_read && bus.m_write));

  a_one_resp: assert property (@(posedge clk) disable iff (!rst_n)
    !(bus.i_resp && bus.d_resp));

endmodule

// File: tb/tb_mem_arbiter.sv
`timescale 1ns/1ps
// tb_mem_arbiter
// Directed corner cases followed by a randomized run. In the random run two
// requester processes model the caches, a memory process answers with a
// random latency, and a monitor predicts each grant from the arbitration
// rules (request pattern in the IDLE cycle plus a count of data grants made
// while a fetch waited) and compares against what the DUT presents.
module tb_mem_arbiter;
  localparam int LINE_W     = 256;
  localparam int ADDR_W     = 32;
  localparam int STARVE_MAX = 4;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  mem_arbiter_if #(.LINE_W(LINE_W), .ADDR_W(ADDR_W)) bus ();

  mem_arbiter #(
    .LINE_W    (LINE_W),
    .ADDR_W    (ADDR_W),
    .STARVE_MAX(STARVE_MAX)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic              wr;
    logic [LINE_W-1:0] wdata;
  } dreq_t;

  logic [ADDR_W-1:0] i_q[$];
  dreq_t             d_q[$];
  logic [LINE_W-1:0] r_q[$];

  int n_pass  = 0;
  int n_total = 0;
  int n_igrant = 0, n_dgrant = 0, n_forced = 0;
  bit stop_req = 0, stop_mon = 0, mem_stop = 0;
  bit i_done = 0, d_done = 0;
  bit mon_busy = 0, mon_owner_d = 0;

  task automatic chk(input string name, input logic [LINE_W-1:0] act,
                     input logic [LINE_W-1:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [LINE_W-1:0] rand_line();
    logic [LINE_W-1:0] r;
    for (int unsigned k = 0; k < LINE_W / 32; k++) r[k*32 +: 32] = $urandom;
    return r;
  endfunction

  // ---------------------------------------------------------------------
  // Random-phase processes
  // ---------------------------------------------------------------------
  task automatic run_icache();
    int idle, w;
    bit got;
    tick();
    while (!stop_req) begin
      idle = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 4);
      repeat (idle) tick();
      bus.i_addr = $urandom & 32'hFFFF_FFE0;
      bus.i_read = 1'b1;
      i_q.push_back(bus.i_addr);
      got = 0;
      w   = 0;
      while (!got && w < 200) begin
        @(negedge clk);
        got = bus.i_resp;
        tick();
        w++;
        if (!got && mon_busy && !mon_owner_d) begin
          if ($urandom_range(0, 3) == 0) bus.i_read = 1'b0;
          bus.i_addr = $urandom;
        end
      end
      chk("icache resp arrives", got, 1'b1);
      bus.i_read = 1'b0;
    end
    i_done = 1;
  endtask

  task automatic run_dcache();
    int idle, w, r;
    bit got;
    dreq_t e;
    tick();
    while (!stop_req) begin
      idle = ($urandom_range(0, 7) < 5) ? 0 : $urandom_range(1, 3);
      repeat (idle) tick();
      r = $urandom_range(0, 9);
      bus.d_addr  = $urandom & 32'hFFFF_FFE0;
      bus.d_wdata = rand_line();
      bus.d_read  = (r < 4) || (r >= 8);
      bus.d_write = (r >= 4);
      e.addr  = bus.d_addr;
      e.wr    = bus.d_write;
      e.wdata = bus.d_wdata;
      d_q.push_back(e);
      got = 0;
      w   = 0;
      while (!got && w < 200) begin
        @(negedge clk);
        got = bus.d_resp;
        tick();
        w++;
        if (!got && mon_busy && mon_owner_d) begin
          if ($urandom_range(0, 3) == 0) begin
            bus.d_read  = 1'b0;
            bus.d_write = 1'b0;
          end
          bus.d_addr  = $urandom;
          bus.d_wdata = rand_line();
        end
      end
      chk("dcache resp arrives", got, 1'b1);
      bus.d_read  = 1'b0;
      bus.d_write = 1'b0;
    end
    d_done = 1;
  endtask

  task automatic run_mem();
    int lat;
    logic [LINE_W-1:0] rd;
    while (!mem_stop) begin
      tick();
      if (bus.m_read || bus.m_write) begin
        lat = $urandom_range(0, 3);
        repeat (lat) tick();
        rd = rand_line();
        bus.m_rdata = rd;
        bus.m_resp  = 1'b1;
        r_q.push_back(rd);
        tick();
        bus.m_resp  = 1'b0;
        bus.m_rdata = rand_line();
      end
    end
  endtask

  task automatic run_monitor();
    bit pend = 0, busy = 0, own_d = 0, wr = 0, ireq, dreq;
    int starve = 0, busy_cyc = 0;
    logic [ADDR_W-1:0] ea = '0;
    logic [LINE_W-1:0] ew = '0, rd;
    dreq_t dr;
    while (!stop_mon) begin
      @(negedge clk);
      ireq = bus.i_read;
      dreq = bus.d_read | bus.d_write;
      if (pend) begin
        pend        = 0;
        busy        = 1;
        busy_cyc    = 0;
        mon_busy    = 1;
        mon_owner_d = own_d;
        if (own_d && wr) chk("grant m_wdata", bus.m_wdata, ew);
      end
      if (busy) begin
        busy_cyc++;
        chk("busy m_read", bus.m_read, !(own_d && wr));
        chk("busy m_write", bus.m_write, own_d && wr);
        chk("busy m_addr", bus.m_addr, ea);
        if (bus.m_resp) begin
          rd = (r_q.size() > 0) ? r_q.pop_front() : '0;
          chk("resp i_resp", bus.i_resp, !own_d);
          chk("resp d_resp", bus.d_resp, own_d);
          chk(own_d ? "resp d_rdata" : "resp i_rdata",
              own_d ? bus.d_rdata : bus.i_rdata, rd);
          busy     = 0;
          mon_busy = 0;
        end else begin
          chk("busy no resp", {bus.i_resp, bus.d_resp}, '0);
          if (busy_cyc > 20) begin
            chk("busy timeout", 1'b0, 1'b1);
            busy     = 0;
            mon_busy = 0;
          end
        end
      end else begin
        chk("idle outputs", {bus.m_read, bus.m_write, bus.i_resp, bus.d_resp}, '0);
        if (ireq && (!dreq || starve == STARVE_MAX)) begin
          if (dreq) n_forced++;
          n_igrant++;
          starve = 0;
          own_d  = 0;
          wr     = 0;
          chk("i_q has entry", i_q.size() > 0, 1'b1);
          ea   = (i_q.size() > 0) ? i_q.pop_front() : '0;
          pend = 1;
        end else if (dreq) begin
          n_dgrant++;
          starve = ireq ? ((starve < STARVE_MAX) ? starve + 1 : starve) : 0;
          own_d  = 1;
          chk("d_q has entry", d_q.size() > 0, 1'b1);
          if (d_q.size() > 0) begin
            dr = d_q.pop_front();
            ea = dr.addr;
            wr = dr.wr;
            ew = dr.wdata;
          end
          pend = 1;
        end
      end
    end
  endtask

  // ---------------------------------------------------------------------
  // Main sequence
  // ---------------------------------------------------------------------
  initial begin
    int w;
    bus.i_read = 0; bus.i_addr = '0;
    bus.d_read = 0; bus.d_write = 0; bus.d_addr = '0; bus.d_wdata = '0;
    bus.m_rdata = '0; bus.m_resp = 0;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;

    // Reset dominates pending requests
    bus.i_read = 1'b1;
    bus.d_write = 1'b1;
    repeat (2) tick();
    @(negedge clk);
    chk("rst m_read", bus.m_read, 1'b0);
    chk("rst m_write", bus.m_write, 1'b0);
    chk("rst resps", {bus.i_resp, bus.d_resp}, '0);
    chk("rst m_addr", bus.m_addr, '0);
    chk("rst m_wdata", bus.m_wdata, '0);
    tick();
    rst_n = 1'b1;
    bus.i_read = 1'b0;
    bus.d_write = 1'b0;

    // Stray m_resp in IDLE
    tick();
    bus.m_resp = 1'b1;
    bus.m_rdata = {32{8'h5A}};
    @(negedge clk);
    chk("stray resps", {bus.i_resp, bus.d_resp}, '0);
    chk("stray strobes", {bus.m_read, bus.m_write}, '0);
    tick();
    bus.m_resp = 1'b0;
    @(negedge clk);
    chk("stray stays idle", {bus.m_read, bus.m_write}, '0);

    // Simultaneous I + illegal D read/write; D address changes during BUSY
    tick();
    bus.i_read = 1'b1;  bus.i_addr = 32'h0000_1040;
    bus.d_read = 1'b1;  bus.d_write = 1'b1;
    bus.d_addr = 32'h0000_2000; bus.d_wdata = {16{16'h1234}};
    @(negedge clk);
    chk("grant latency", {bus.m_read, bus.m_write}, '0);
    tick();
    bus.d_addr = 32'h0000_3000; bus.d_wdata = {32{8'hEE}};
    @(negedge clk);
    chk("viol m_write", bus.m_write, 1'b1);
    chk("viol m_read", bus.m_read, 1'b0);
    chk("viol m_addr", bus.m_addr, 32'h0000_2000);
    chk("viol m_wdata", bus.m_wdata, {16{16'h1234}});
    tick();
    @(negedge clk);
    chk("hold m_addr", bus.m_addr, 32'h0000_2000);
    chk("hold m_write", {bus.m_read, bus.m_write}, 2'b01);
    tick();
    bus.m_resp = 1'b1; bus.m_rdata = {32{8'hA5}};
    @(negedge clk);
    chk("d resp", {bus.i_resp, bus.d_resp}, 2'b01);
    chk("d_rdata", bus.d_rdata, {32{8'hA5}});
    tick();
    bus.m_resp = 1'b0; bus.d_read = 1'b0; bus.d_write = 1'b0;
    @(negedge clk);
    chk("gap strobes", {bus.m_read, bus.m_write}, '0);
    tick();
    @(negedge clk);
    chk("i grant strobes", {bus.m_read, bus.m_write}, 2'b10);
    chk("i grant m_addr", bus.m_addr, 32'h0000_1040);
    tick();
    tick();
    bus.m_resp = 1'b1; bus.m_rdata = {32{8'hA5}};
    @(negedge clk);
    chk("i resp", {bus.i_resp, bus.d_resp}, 2'b10);
    chk("i_rdata", bus.i_rdata, {32{8'hA5}});
    tick();
    bus.m_resp = 1'b0; bus.i_read = 1'b0;
    @(negedge clk);
    chk("i drop strobe", {bus.m_read, bus.m_write}, '0);

    // Zero-wait memory: resp in first BUSY cycle
    tick();
    bus.d_read = 1'b1; bus.d_addr = 32'h0000_4000;
    tick();
    bus.m_resp = 1'b1; bus.m_rdata = {8{32'hC0FFEE11}};
    @(negedge clk);
    chk("zw m_read", {bus.m_read, bus.m_write}, 2'b10);
    chk("zw d_resp", {bus.i_resp, bus.d_resp}, 2'b01);
    tick();
    bus.m_resp = 1'b0; bus.d_read = 1'b0;
    @(negedge clk);
    chk("zw drop", {bus.m_read, bus.m_write}, '0);

    // Reset mid-D_BUSY, then a late m_resp
    tick();
    bus.d_write = 1'b1; bus.d_addr = 32'h0000_5000; bus.d_wdata = {32{8'h3C}};
    tick();
    @(negedge clk);
    chk("abort pre m_write", bus.m_write, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("abort m_write", bus.m_write, 1'b0);
    chk("abort m_addr", bus.m_addr, '0);
    chk("abort m_wdata", bus.m_wdata, '0);
    tick();
    rst_n = 1'b1; bus.d_write = 1'b0;
    tick();
    bus.m_resp = 1'b1;
    @(negedge clk);
    chk("late d_resp", {bus.i_resp, bus.d_resp}, '0);
    chk("late strobes", {bus.m_read, bus.m_write}, '0);
    tick();
    bus.m_resp = 1'b0;

    // Randomized run against the reference model
    fork
      run_icache();
      run_dcache();
      run_mem();
      run_monitor();
      begin
        repeat (3000) @(posedge clk);
        stop_req = 1;
        w = 0;
        while (!(i_done && d_done) && w < 500) begin
          @(posedge clk);
          w++;
        end
        chk("requesters drain", i_done && d_done, 1'b1);
        repeat (10) @(posedge clk);
        mem_stop = 1;
        stop_mon = 1;
      end
    join

    chk("i_q empty", i_q.size() == 0, 1'b1);
    chk("d_q empty", d_q.size() == 0, 1'b1);
    chk("saw i grants", n_igrant > 0, 1'b1);
    chk("saw d grants", n_dgrant > 0, 1'b1);
    chk("saw forced i grant", n_forced > 0, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
